// File: rtl/q1_sweep_pkg.sv
// Shared types and constants for the q1 vector sweeper.
// Holds the sweep FSM state type, the vector count and the counter widths.
package q1_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int NUM_VECTORS = 16;
    localparam int VEC_W       = 4;
    localparam int CNT_W       = 8;

endpackage

// File: rtl/q1_hold_timer.sv
// Hold counter for the q1 sweeper: counts 0..HOLD_CYCLES-1 and wraps.
// Ports: clk, rst_n, i_clear (load 0), i_en (count), o_last (count at end).
module q1_hold_timer
    import q1_sweep_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == LAST_CNT);
    assign o_last = w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            // Wrap on the last hold cycle so the next vector starts at 0.
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/q1_vec_sweeper.sv
// Clocked self-checking sweep of all 16 q1 input vectors against EXP_F/EXP_G.
// Ports: clk, rst_n, start; a..d to q1; f_in/g_in from q1; busy, done, pass,
// err_count, first_err_vec, first_err_valid result outputs.
module q1_vec_sweeper
    import q1_sweep_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 20,
    parameter logic [15:0] EXP_F       = 16'h0000,
    parameter logic [15:0] EXP_G       = 16'h0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    input  logic       f_in,
    input  logic       g_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_err_vec,
    output logic       first_err_valid
);

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

    state_t           r_state;
    logic [VEC_W-1:0] r_vec;
    logic [4:0]       r_err_cnt;
    logic [3:0]       r_first_vec;
    logic             r_first_valid;
    logic             r_pass;

    logic             w_last;
    logic             w_sample;
    logic             w_mis;
    logic [4:0]       w_err_next;
    logic             w_clear;

    // Counter sits at 0 whenever idle, so RUN always begins a fresh hold.
    assign w_clear = (r_state != RUN);

    q1_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clear(w_clear),
        .i_en   (r_state == RUN),
        .o_last (w_last)
    );

    assign w_sample   = (r_state == RUN) && w_last;
    assign w_mis      = ({f_in, g_in} != {EXP_F[r_vec], EXP_G[r_vec]});
    assign w_err_next = r_err_cnt + {4'd0, w_sample && w_mis};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_vec         <= '0;
            r_err_cnt     <= '0;
            r_first_vec   <= '0;
            r_first_valid <= 1'b0;
            r_pass        <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_vec <= '0;
                    if (start) begin
                        r_state       <= RUN;
                        r_err_cnt     <= '0;
                        r_first_vec   <= '0;
                        r_first_valid <= 1'b0;
                        r_pass        <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_sample) begin
                        r_err_cnt <= w_err_next;
                        if (w_mis && !r_first_valid) begin
                            r_first_vec   <= r_vec;
                            r_first_valid <= 1'b1;
                        end
                        if (r_vec == LAST_VEC) begin
                            r_state <= FINISH;
                            // Uses the updated count so pass lines up with done.
                            r_pass  <= (w_err_next == 5'd0);
                        end else begin
                            r_vec <= r_vec + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                    r_vec   <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_vec   <= '0;
                end
            endcase
        end
    end

    assign {a, b, c, d}    = r_vec;
    assign busy            = (r_state != IDLE);
    assign done            = (r_state == FINISH);
    assign pass            = r_pass;
    assign err_count       = r_err_cnt;
    assign first_err_vec   = r_first_vec;
    assign first_err_valid = r_first_valid;

endmodule

// File: tb/tb_q1_vec_sweeper.sv
// Scoreboard bench for q1_vec_sweeper driving a table-based q1 model.
// Instance A uses H=20; instance B uses H=2 for back-to-back sweeps.
module tb_q1_vec_sweeper;

    localparam int          HA   = 20;
    localparam int          HB   = 2;
    localparam logic [15:0] F_TT = 16'hA5A5;
    localparam logic [15:0] G_TT = 16'h3C96;

    typedef struct {
        int err;
        int first;
        int fvalid;
        int pass;
        int busy;
        int done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start_a, start_b;
    logic aa, ab, ac, ad, ba, bb, bc, bd;
    logic fa, ga, fb, gb;
    logic busy_a, done_a, pass_a, fvld_a;
    logic busy_b, done_b, pass_b, fvld_b;
    logic [4:0] err_a, err_b;
    logic [3:0] fvec_a, fvec_b;

    int   fm_a = 0;
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;
    int   ndone_a = 0, ndone_b = 0;
    int   bcnt_a = 0, bcnt_b = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [1:0] q1m(input logic [3:0] v, input int mode);
        logic f, g;
        f = F_TT[v];
        g = G_TT[v];
        if (mode == 1) f = 1'b0;
        if (mode == 2 && v == 4'd12) begin
            f = ~f;
            g = ~g;
        end
        return {f, g};
    endfunction

    assign {fa, ga} = q1m({aa, ab, ac, ad}, fm_a);
    assign {fb, gb} = q1m({ba, bb, bc, bd}, 0);

    q1_vec_sweeper #(.HOLD_CYCLES(HA), .EXP_F(F_TT), .EXP_G(G_TT)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .a(aa), .b(ab), .c(ac), .d(ad), .f_in(fa), .g_in(ga),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_err_vec(fvec_a), .first_err_valid(fvld_a)
    );

    q1_vec_sweeper #(.HOLD_CYCLES(HB), .EXP_F(F_TT), .EXP_G(G_TT)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .a(ba), .b(bb), .c(bc), .d(bd), .f_in(fb), .g_in(gb),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_err_vec(fvec_b), .first_err_valid(fvld_b)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_run++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t predict(input int mode, input int h, input int n);
        exp_t e;
        logic [1:0] m;
        e.err = 0;
        e.first = 0;
        e.fvalid = 0;
        for (int v = 0; v < 16; v++) begin
            m = q1m(4'(v), mode);
            if (m != {F_TT[v], G_TT[v]}) begin
                if (e.fvalid == 0) e.first = v;
                e.fvalid = 1;
                e.err++;
            end
        end
        e.pass = (e.err == 0);
        e.busy = 16 * h + 1;
        e.done_cyc = n + 16 * h;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (busy_a) bcnt_a++; else bcnt_a = 0;
        if (busy_b) bcnt_b++; else bcnt_b = 0;
        if (done_a) begin
            if (sb_a.size() == 0) chk("a_sb_empty", 1, 0);
            else begin
                e = sb_a.pop_front();
                chk("a_err", err_a, e.err);
                chk("a_first", fvec_a, e.first);
                chk("a_fvalid", fvld_a, e.fvalid);
                chk("a_pass", pass_a, e.pass);
                chk("a_busy_len", bcnt_a, e.busy);
                chk("a_done_cyc", cyc, e.done_cyc);
            end
            ndone_a++;
        end
        if (done_b) begin
            if (sb_b.size() == 0) chk("b_sb_empty", 1, 0);
            else begin
                e = sb_b.pop_front();
                chk("b_err", err_b, e.err);
                chk("b_first", fvec_b, e.first);
                chk("b_fvalid", fvld_b, e.fvalid);
                chk("b_pass", pass_b, e.pass);
                chk("b_busy_len", bcnt_b, e.busy);
                chk("b_done_cyc", cyc, e.done_cyc);
            end
            ndone_b++;
        end
    end

    function automatic int outs_a();
        return int'({aa, ab, ac, ad, busy_a, done_a, pass_a,
                     err_a, fvec_a, fvld_a});
    endfunction

    task automatic start_sweep_a(input int mode);
        @(negedge clk);
        fm_a = mode;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        sb_a.push_back(predict(mode, HA, cyc));
        chk("a_busy_on", busy_a, 1);
        chk("a_vec0", {aa, ab, ac, ad}, 0);
        chk("a_err_clr", err_a, 0);
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a();
        int s = ndone_a;
        int k = 0;
        while (ndone_a == s && k < 500) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("a_done_seen", int'(ndone_a != s), 1);
        @(negedge clk);
        chk("a_busy_off", busy_a, 0);
        chk("a_pass_hold", pass_a, sb_a.size() == 0 ? int'(pass_a) : 0);
    endtask

    initial begin
        exp_t eb;
        int   k;
        int   nb;
        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outs_a", outs_a(), 0);
        chk("rst_busy_b", busy_b, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Correct model.
        start_sweep_a(0);
        wait_done_a();

        // f stuck at 0.
        start_sweep_a(1);
        wait_done_a();

        // start pulsed while busy must not restart.
        start_sweep_a(0);
        repeat (48) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("a_no_restart_vec", {aa, ab, ac, ad}, 2);
        wait_done_a();

        // Reset mid-sweep at vector 7.
        start_sweep_a(1);
        k = 0;
        while ({aa, ab, ac, ad} != 4'd7 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("a_reach_vec7", {aa, ab, ac, ad}, 7);
        chk("a_err_before_rst", int'(err_a != 0), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("a_rst_mid_outs", outs_a(), 0);
        sb_a.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_sweep_a(0);
        wait_done_a();

        // f and g both wrong only on vector 12.
        start_sweep_a(2);
        wait_done_a();

        // H=2 back-to-back sweeps on instance B.
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            start_b = 1'b1;
            @(posedge clk);
            #1;
            sb_b.push_back(predict(0, HB, cyc));
            chk("b_busy_on", busy_b, 1);
            @(negedge clk);
            start_b = 1'b0;
            nb = ndone_b;
            k = 0;
            while (ndone_b == nb && k < 100) begin
                @(negedge clk);
                #1;
                k++;
            end
            chk("b_done_seen", int'(ndone_b != nb), 1);
        end
        chk("b_sweeps", ndone_b, 2);
        chk("a_sb_left", sb_a.size(), 0);
        chk("b_sb_left", sb_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
